// File: rtl/run_latency_logger_pkg.sv
// Shared definitions for the run latency logger: FSM state encoding,
// default widths/depths and the saturation limit of the latency timer.
package run_latency_logger_pkg;

  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned DEPTH_DEF  = 4;
  localparam int unsigned ADDR_W_DEF = 2;

  // Largest latency representable with the default timer width.
  localparam logic [CNT_W_DEF-1:0] TIMER_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MEASURE  = 2'd1,
    ST_WAIT_LOW = 2'd2
  } state_e;

endpackage : run_latency_logger_pkg

// File: rtl/run_latency_logger_fifo.sv
// sync_fifo_fwft: first-word-fall-through FIFO with occupancy count and a
// sticky overflow flag.
//   clk, rst     : clock, synchronous active-low reset
//   push_i       : write push_data_i (dropped when full with no pop)
//   pop_ready_i  : consumer accepts the head entry
//   valid_o      : FIFO non-empty
//   data_o       : head entry, read combinationally from storage
//   count_o      : occupancy 0..DEPTH
//   ovf_o        : set when a push was dropped; cleared only by reset
module sync_fifo_fwft #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  push_data_i,
  input  logic              pop_ready_i,
  output logic              valid_o,
  output logic [WIDTH-1:0]  data_o,
  output logic [ADDR_W:0]   count_o,
  output logic              ovf_o
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q;

  logic full_c, do_pop_c, do_push_c, drop_c;

  // A full FIFO still accepts a push when the head is popped on the same edge;
  // the write lands in the slot being vacated, which becomes the new tail.
  always_comb begin
    full_c    = (count_q == FULL_CNT);
    do_pop_c  = valid_o && pop_ready_i;
    do_push_c = push_i && (!full_c || do_pop_c);
    drop_c    = push_i && full_c && !do_pop_c;
  end

  always_comb begin
    count_d = count_q;
    case ({do_push_c, do_pop_c})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push_c) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + ADDR_W'(1);
      end
      if (do_pop_c) rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      count_q <= count_d;
      if (drop_c) ovf_q <= 1'b1;
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;

endmodule : sync_fifo_fwft

// File: rtl/run_latency_logger.sv
// run_latency_logger: times each start->done run of the upstream controller
// and queues the latency (in clock edges) into an FWFT event FIFO.
//   clk, rst          : clock, synchronous active-low reset
//   s, g              : start strobe and done level from the controller
//   ev_valid/ev_ready : event FIFO handshake, ev_data is the head latency
//   ev_count          : FIFO occupancy 0..DEPTH
//   ovf               : sticky, a measurement was dropped on a full FIFO
//   busy              : FSM not in IDLE
module run_latency_logger
  import run_latency_logger_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s,
  input  logic              g,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [CNT_W-1:0]  ev_data,
  output logic [ADDR_W:0]   ev_count,
  output logic              ovf,
  output logic              busy
);

  // Saturation limit for this instance's timer width.
  localparam logic [CNT_W-1:0] TMAX = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             busy_q;
  logic             push_c;

  // State register; busy is registered alongside the state it reflects.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  // Next-state logic. WAIT_LOW ignores s so a long g yields one entry.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (s) state_d = ST_MEASURE;
      ST_MEASURE:  if (g) state_d = ST_WAIT_LOW;
      ST_WAIT_LOW: if (!g) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Timer and push. The timer starts at 1 on the start edge so the value
  // pushed on the done edge equals the number of edges between them.
  always_comb begin
    timer_d = timer_q;
    push_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s) timer_d = CNT_W'(1);
      end
      ST_MEASURE: begin
        if (g) begin
          push_c = 1'b1;
        end else if (timer_q != TMAX) begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        timer_d = timer_q;
      end
    endcase
  end

  sync_fifo_fwft #(
    .WIDTH  (CNT_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_c),
    .push_data_i (timer_q),
    .pop_ready_i (ev_ready),
    .valid_o     (ev_valid),
    .data_o      (ev_data),
    .count_o     (ev_count),
    .ovf_o       (ovf)
  );

  assign busy = busy_q;

endmodule : run_latency_logger

// File: doc/run_latency_logger.md
Name: run_latency_logger

Overview:
- Downstream consumer of the start/count/flag datapath (start strobe `s`, 4-bit counter, done flag `g`).
- Measures, for each run, the number of clock edges from the edge that samples the start strobe to the edge that samples the done flag high.
- Each measurement goes into a small first-word-fall-through (FWFT) event FIFO. A host or monitor drains it with a valid/ready handshake.
- Sits in the same clock domain as the controller.

Parameters:
- CNT_W, 8, width of the latency timer and of each FIFO entry.
- DEPTH, 4, number of FIFO entries; must be a power of 2.
- ADDR_W, 2, log2(DEPTH).

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-low.
- s  input  1  start strobe, same signal that starts the upstream controller.
- g  input  1  done flag from the upstream controller; level signal, may stay high for several cycles.
- ev_valid  output  1  FIFO non-empty.
- ev_ready  input  1  consumer accepts the head entry.
- ev_data  output  CNT_W  head-of-FIFO latency value.
- ev_count  output  ADDR_W+1  current FIFO occupancy, 0..DEPTH.
- ovf  output  1  sticky flag: at least one measurement was dropped.
- busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Reset: rst==0 at a rising clk edge has the following effect.
  - state=IDLE, timer=0, read/write pointers=0, ev_count=0.
  - All FIFO entries=0, ev_valid=0, ev_data=0, ovf=0, busy=0.
  - Reset overrides every other event in the same cycle, including a mid-run reset: the partial measurement is discarded and nothing is pushed.
- FSM, states IDLE, MEASURE, WAIT_LOW:
  - IDLE: if s==1, timer<=1 and go to MEASURE; otherwise stay. In IDLE, g is ignored.
  - MEASURE: if g==1, push timer and go to WAIT_LOW. Otherwise timer<=timer+1, saturating at 2^CNT_W-1 (no wrap). s is ignored.
  - WAIT_LOW: stay while g==1; go to IDLE when g==0. s is ignored, so each run yields exactly one entry however long g is held.
- Latency definition: if s is sampled at edge k and g at edge k+N, the pushed value is N (N>=1), clipped to 2^CNT_W-1.
- busy = (state != IDLE), registered together with state.
- FIFO (FWFT):
  - ev_valid = (ev_count != 0).
  - ev_data = entry at the read pointer, combinational from storage.
  - Pop occurs when ev_valid && ev_ready.
  - A push into an empty FIFO appears at ev_data with ev_valid=1 on the cycle after the push edge (1-cycle latency).
- Simultaneous push and pop: both take effect and ev_count is unchanged. This also applies when full, in which case the push is accepted and ovf is not set.
- Push while full with no pop: the entry is dropped, FIFO contents and ev_count are unchanged, and ovf<=1. ovf clears only on reset.
- Pop while empty: no effect.
- Pointers wrap modulo DEPTH. ev_count is an ADDR_W+1-bit occupancy register, so full (==DEPTH) and empty (==0) are unambiguous.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_MEASURE=2'd1, ST_WAIT_LOW=2'd2;
  - default CNT_W/DEPTH values;
  - TIMER_MAX constant.
- One natural sub-module: sync_fifo_fwft. It is parameterised by width and depth and implements the push/pop/count/overflow rules above.
- The top level holds the FSM, timer and busy logic.

Test Plan:
- Reset: hold rst=0 for 3 edges with s=1, g=1 -> all outputs 0, state IDLE; release -> busy rises on the first s=1 edge.
- Basic run: s=1 at edge 10, g=1 at edge 30 -> ev_data=20, ev_valid=1 from the cycle after edge 30, ev_count=1; ev_ready=1 for one edge -> ev_count=0.
- g held high 6 cycles, s pulsed during WAIT_LOW -> exactly one entry, and no new run starts until g falls and a later s=1 arrives.
- Overflow: 5 runs with latencies 3,4,5,6,7 and ev_ready=0 -> ev_count=4, ovf=1; draining yields 3,4,5,6 in order, then ev_valid=0; ovf stays 1.
- Saturation: g asserted 300 edges after s -> pushed value 255.
- Full with simultaneous pop and push (ev_ready=1 on the push edge) -> ev_count stays 4, ovf=0, and the new value is last in the drain order.
- Mid-run reset: rst=0 while in MEASURE at timer=9 -> after release, no entry exists and ev_count=0.
